// File: rtl/disp_regs_pkg.sv
// disp_regs_pkg: register map constants and helpers for the layered display register block.
// Latency: n/a (constants and combinational helpers only).
// Backpressure: n/a.
package disp_regs_pkg;

    // Register word indices (byte address [11:2]).
    localparam logic [9:0] IDX_CTRL       = 10'h000;
    localparam logic [9:0] IDX_STATUS     = 10'h001;
    localparam logic [9:0] IDX_INTEN      = 10'h002;
    localparam logic [9:0] IDX_INTSTAT    = 10'h003;
    localparam logic [9:0] IDX_FIFOSTAT   = 10'h004;
    localparam logic [9:0] IDX_FRAMECNT   = 10'h005;
    localparam logic [9:0] IDX_LAYER_BASE = 10'h040;

    // Each layer owns two words: ADDR then ctrl.
    localparam int LAYER_STRIDE     = 2;
    localparam int LAYER_STRIDE_LG2 = $clog2(LAYER_STRIDE);

    // CTRL bits
    localparam int CTRL_DISPON = 0;
    localparam int CTRL_UPDREQ = 1;

    // STATUS bits
    localparam int STAT_VBLANK = 0;

    // INTEN / INTSTAT bits
    localparam int INT_VBLANK  = 0;
    localparam int INT_FIFOERR = 1;
    localparam int INT_COMMIT  = 2;

    // FIFOSTAT: underflow flags at [NLAYER-1:0], overflow flags from this bit up.
    localparam int FIFO_OVER_OFS = 16;

    // Expand 4 byte enables into a 32-bit lane mask.
    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/disp_vsync_sync.sv
// disp_vsync_sync: 3-flop synchroniser for the active-low display VSYNC plus falling-edge pulse.
// Latency: low sampled at edge t0 -> EDGE high during the t1..t2 cycle (state using it updates at t2).
// Backpressure: none; EDGE is a single-cycle pulse per VSYNC assertion.
// Ports: ACLK clock, ARST sync active-high reset, DSP_VSYNC_X async VSYNC (active-low), EDGE pulse out.
module disp_vsync_sync (
    input  logic ACLK,
    input  logic ARST,
    input  logic DSP_VSYNC_X,
    output logic EDGE
);

    logic [2:0] r_sync;

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[1:0], DSP_VSYNC_X};
        end
    end

    // High-to-low transition between the two oldest stages. Reset leaves the
    // chain at 0, so a VSYNC idling high after reset only yields a rising
    // transition, never a spurious falling edge.
    assign EDGE = !r_sync[1] & r_sync[2];

endmodule

// File: rtl/disp_layer_regctrl.sv
// disp_layer_regctrl: multi-layer display register block with double-buffered layer base/enable and DSP_IRQ.
// Latency: register writes visible next cycle; RDATA one cycle after RDEN; staging commits on VSYNC fall.
// Backpressure: none; bus accesses complete in a single cycle.
// Ports: ACLK/ARST (sync active-high); WRADDR/BYTEEN/WREN/WDATA write port; RDADDR/RDEN/RDATA read port;
//        DSP_VSYNC_X async VSYNC; BUF_UNDER/BUF_OVER FIFO error pulses; DISPON, LAYER_EN, LAYER_ADDR, DSP_IRQ.
// Optional: define DISP_FRAME_CNT_EN to add the FRAMECNT frame counter at 0x014.
module disp_layer_regctrl
    import disp_regs_pkg::*;
#(
    parameter int          NLAYER   = 2,
    parameter int          ADDR_W   = 29,
    parameter logic [3:0]  BLOCK_ID = 4'd0
) (
    input  logic                     ACLK,
    input  logic                     ARST,
    input  logic                     DSP_VSYNC_X,
    input  logic [15:0]              WRADDR,
    input  logic [3:0]               BYTEEN,
    input  logic                     WREN,
    input  logic [31:0]              WDATA,
    input  logic [15:0]              RDADDR,
    input  logic                     RDEN,
    output logic [31:0]              RDATA,
    output logic                     DISPON,
    output logic [NLAYER-1:0]        LAYER_EN,
    output logic [NLAYER*ADDR_W-1:0] LAYER_ADDR,
    output logic                     DSP_IRQ,
    input  logic [NLAYER-1:0]        BUF_UNDER,
    input  logic [NLAYER-1:0]        BUF_OVER
);

    localparam logic [8:0] NLAYER_L = 9'(NLAYER);

    logic w_edge;

    disp_vsync_sync u_vsync (
        .ACLK        (ACLK),
        .ARST        (ARST),
        .DSP_VSYNC_X (DSP_VSYNC_X),
        .EDGE        (w_edge)
    );

    // ---------------- state ----------------
    logic                           r_dispon;
    logic                           r_pending;
    logic                           r_vblank;
    logic                           r_int_vblank;
    logic                           r_int_commit;
    logic [2:0]                     r_inten;
    logic [NLAYER-1:0]              r_under;
    logic [NLAYER-1:0]              r_over;
    logic [NLAYER-1:0][ADDR_W-1:0]  r_stg_addr;
    logic [NLAYER-1:0]              r_stg_en;
    logic [NLAYER-1:0][ADDR_W-1:0]  r_act_addr;
    logic [NLAYER-1:0]              r_act_en;
    logic                           r_irq;
    logic [31:0]                    r_rdata;

    // ---------------- write decode ----------------
    logic        w_wr_hit;
    logic [9:0]  w_wr_idx;
    logic [9:0]  w_wr_off;
    logic [8:0]  w_wr_lyr;
    logic        w_wr_lyr_hit;
    logic        w_wr_ctrl, w_wr_status, w_wr_inten, w_wr_intstat, w_wr_fifo;
    logic [31:0] w_be_mask;
    logic [31:0] w_w1c;

    assign w_wr_hit     = WREN && (WRADDR[15:12] == BLOCK_ID);
    assign w_wr_idx     = WRADDR[11:2];
    assign w_wr_off     = w_wr_idx - IDX_LAYER_BASE;
    assign w_wr_lyr     = 9'(w_wr_off >> LAYER_STRIDE_LG2);
    assign w_wr_lyr_hit = w_wr_hit && (w_wr_idx >= IDX_LAYER_BASE) && (w_wr_lyr < NLAYER_L);
    assign w_wr_ctrl    = w_wr_hit && (w_wr_idx == IDX_CTRL);
    assign w_wr_status  = w_wr_hit && (w_wr_idx == IDX_STATUS);
    assign w_wr_inten   = w_wr_hit && (w_wr_idx == IDX_INTEN);
    assign w_wr_intstat = w_wr_hit && (w_wr_idx == IDX_INTSTAT);
    assign w_wr_fifo    = w_wr_hit && (w_wr_idx == IDX_FIFOSTAT);
    assign w_be_mask    = be_mask(BYTEEN);
    assign w_w1c        = WDATA & w_be_mask;

    // ---------------- read decode ----------------
    logic        w_rd_blk;
    logic [9:0]  w_rd_idx;
    logic [9:0]  w_rd_off;
    logic [8:0]  w_rd_lyr;
    logic        w_rd_lyr_hit;
    logic [31:0] w_rd_dat;
    logic [31:0] w_framecnt;

    assign w_rd_blk     = (RDADDR[15:12] == BLOCK_ID);
    assign w_rd_idx     = RDADDR[11:2];
    assign w_rd_off     = w_rd_idx - IDX_LAYER_BASE;
    assign w_rd_lyr     = 9'(w_rd_off >> LAYER_STRIDE_LG2);
    assign w_rd_lyr_hit = (w_rd_idx >= IDX_LAYER_BASE) && (w_rd_lyr < NLAYER_L);

    // ---------------- derived ----------------
    logic              w_commit;
    logic [2:0]        w_intstat;
    logic [NLAYER-1:0] w_under_clr;
    logic [NLAYER-1:0] w_over_clr;
    logic [NLAYER-1:0][ADDR_W-1:0] w_stg_nxt;

    assign w_commit                = w_edge & r_pending;
    assign w_intstat[INT_VBLANK]   = r_int_vblank;
    assign w_intstat[INT_FIFOERR]  = |{r_under, r_over};
    assign w_intstat[INT_COMMIT]   = r_int_commit;
    assign w_under_clr             = w_wr_fifo ? w_w1c[NLAYER-1:0] : '0;
    assign w_over_clr              = w_wr_fifo ? w_w1c[FIFO_OVER_OFS +: NLAYER] : '0;

    // Byte-lane merge of a layer address write; bits at or above ADDR_W are dropped.
    always_comb begin
        w_stg_nxt = '0;
        for (int i = 0; i < NLAYER; i++) begin
            w_stg_nxt[i] = (r_stg_addr[i] & ~w_be_mask[ADDR_W-1:0])
                         | (WDATA[ADDR_W-1:0] & w_be_mask[ADDR_W-1:0]);
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            r_dispon     <= 1'b0;
            r_pending    <= 1'b0;
            r_vblank     <= 1'b0;
            r_int_vblank <= 1'b0;
            r_int_commit <= 1'b0;
            r_inten      <= '0;
            r_under      <= '0;
            r_over       <= '0;
            r_stg_addr   <= '0;
            r_stg_en     <= '0;
            r_act_addr   <= '0;
            r_act_en     <= '0;
            r_irq        <= 1'b0;
            r_rdata      <= '0;
        end else begin
            if (w_wr_ctrl && BYTEEN[0]) begin
                r_dispon <= WDATA[CTRL_DISPON];
            end

            // Commit samples staging before any same-cycle staging write lands.
            if (w_commit) begin
                r_act_addr <= r_stg_addr;
                r_act_en   <= r_stg_en;
                r_pending  <= 1'b0;
            end
            // A request arriving with the edge is held for the next edge.
            if (w_wr_ctrl && BYTEEN[0] && WDATA[CTRL_UPDREQ]) begin
                r_pending <= 1'b1;
            end

            // Sticky flags: clear first, then hardware set so that set wins.
            if (w_wr_status && w_w1c[STAT_VBLANK]) r_vblank <= 1'b0;
            if (w_edge)                            r_vblank <= 1'b1;

            if (w_wr_intstat && w_w1c[INT_VBLANK]) r_int_vblank <= 1'b0;
            if (w_edge)                            r_int_vblank <= 1'b1;

            if (w_wr_intstat && w_w1c[INT_COMMIT]) r_int_commit <= 1'b0;
            if (w_commit)                          r_int_commit <= 1'b1;

            r_under <= (r_under & ~w_under_clr) | BUF_UNDER;
            r_over  <= (r_over  & ~w_over_clr)  | BUF_OVER;

            if (w_wr_inten && BYTEEN[0]) begin
                r_inten <= WDATA[2:0];
            end

            for (int i = 0; i < NLAYER; i++) begin
                if (w_wr_lyr_hit && (w_wr_lyr == 9'(i))) begin
                    if (!w_wr_off[0]) begin
                        r_stg_addr[i] <= w_stg_nxt[i];
                    end else if (BYTEEN[0]) begin
                        r_stg_en[i] <= WDATA[0];
                    end
                end
            end

            r_irq <= |(w_intstat & r_inten);

            if (RDEN && w_rd_blk) begin
                r_rdata <= w_rd_dat;
            end
        end
    end

`ifdef DISP_FRAME_CNT_EN
    logic        w_wr_fcnt;
    logic [31:0] r_framecnt;

    assign w_wr_fcnt = w_wr_hit && (w_wr_idx == IDX_FRAMECNT);

    // Clear takes priority over a coincident edge.
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            r_framecnt <= '0;
        end else if (w_wr_fcnt && (|BYTEEN)) begin
            r_framecnt <= '0;
        end else if (w_edge) begin
            r_framecnt <= r_framecnt + 32'd1;
        end
    end

    assign w_framecnt = r_framecnt;
`else
    assign w_framecnt = '0;
`endif

    always_comb begin
        w_rd_dat = '0;
        if (w_rd_lyr_hit) begin
            for (int i = 0; i < NLAYER; i++) begin
                if (w_rd_lyr == 9'(i)) begin
                    if (!w_rd_off[0]) begin
                        w_rd_dat[ADDR_W-1:0] = r_stg_addr[i];
                    end else begin
                        w_rd_dat[0] = r_stg_en[i];
                    end
                end
            end
        end else begin
            case (w_rd_idx)
                IDX_CTRL: begin
                    w_rd_dat[CTRL_DISPON] = r_dispon;
                    w_rd_dat[CTRL_UPDREQ] = r_pending;
                end
                IDX_STATUS:   w_rd_dat[STAT_VBLANK] = r_vblank;
                IDX_INTEN:    w_rd_dat[2:0] = r_inten;
                IDX_INTSTAT:  w_rd_dat[2:0] = w_intstat;
                IDX_FIFOSTAT: begin
                    w_rd_dat[NLAYER-1:0]              = r_under;
                    w_rd_dat[FIFO_OVER_OFS +: NLAYER] = r_over;
                end
                IDX_FRAMECNT: w_rd_dat = w_framecnt;
                default:      w_rd_dat = '0;
            endcase
        end
    end

    // Low address bits and unused W1C lanes carry no information here.
    logic w_unused;
    assign w_unused = ^{WRADDR[1:0], RDADDR[1:0], w_w1c};

    assign RDATA      = r_rdata;
    assign DISPON     = r_dispon;
    assign LAYER_EN   = r_act_en;
    assign LAYER_ADDR = r_act_addr;
    assign DSP_IRQ    = r_irq;

endmodule

// File: tb/tb_disp_layer_regctrl.sv
module tb_disp_layer_regctrl;

    localparam int NLAYER = 2;
    localparam int ADDR_W = 29;

    logic                     ACLK = 1'b0;
    logic                     ARST;
    logic                     DSP_VSYNC_X;
    logic [15:0]              WRADDR;
    logic [3:0]               BYTEEN;
    logic                     WREN;
    logic [31:0]              WDATA;
    logic [15:0]              RDADDR;
    logic                     RDEN;
    logic [31:0]              RDATA;
    logic                     DISPON;
    logic [NLAYER-1:0]        LAYER_EN;
    logic [NLAYER*ADDR_W-1:0] LAYER_ADDR;
    logic                     DSP_IRQ;
    logic [NLAYER-1:0]        BUF_UNDER;
    logic [NLAYER-1:0]        BUF_OVER;

    int n_chk = 0;
    int n_bad = 0;

    always #5 ACLK = ~ACLK;

    disp_layer_regctrl #(.NLAYER(NLAYER), .ADDR_W(ADDR_W), .BLOCK_ID(4'd0)) dut (
        .ACLK        (ACLK),
        .ARST        (ARST),
        .DSP_VSYNC_X (DSP_VSYNC_X),
        .WRADDR      (WRADDR),
        .BYTEEN      (BYTEEN),
        .WREN        (WREN),
        .WDATA       (WDATA),
        .RDADDR      (RDADDR),
        .RDEN        (RDEN),
        .RDATA       (RDATA),
        .DISPON      (DISPON),
        .LAYER_EN    (LAYER_EN),
        .LAYER_ADDR  (LAYER_ADDR),
        .DSP_IRQ     (DSP_IRQ),
        .BUF_UNDER   (BUF_UNDER),
        .BUF_OVER    (BUF_OVER)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
        WRADDR = a; WDATA = d; BYTEEN = be; WREN = 1'b1;
        step();
        WREN = 1'b0; BYTEEN = 4'h0;
    endtask

    task automatic rdchk(input string tag, input logic [15:0] a, input logic [31:0] exp);
        RDADDR = a; RDEN = 1'b1;
        step();
        RDEN = 1'b0;
        chk(tag, RDATA, exp);
    endtask

    task automatic vsync_pulse();
        DSP_VSYNC_X = 1'b0;
        repeat (4) step();
        DSP_VSYNC_X = 1'b1;
        repeat (4) step();
    endtask

    // Pulse VSYNC and land one write exactly in the cycle the edge takes effect.
    task automatic vsync_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
        DSP_VSYNC_X = 1'b0;
        step();             // t0: low sampled
        step();             // t1: edge active during this cycle
        WRADDR = a; WDATA = d; BYTEEN = be; WREN = 1'b1;
        step();             // t2: write and edge-driven updates land together
        WREN = 1'b0; BYTEEN = 4'h0;
        DSP_VSYNC_X = 1'b1;
        repeat (4) step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] offs [10];
        logic        irq_seen;
        logic [31:0] exp_fc;

        offs = '{16'h000, 16'h004, 16'h008, 16'h00C, 16'h010,
                 16'h014, 16'h100, 16'h104, 16'h108, 16'h10C};

        ARST = 1'b1; DSP_VSYNC_X = 1'b1;
        WRADDR = '0; BYTEEN = '0; WREN = 1'b0; WDATA = '0;
        RDADDR = '0; RDEN = 1'b0; BUF_UNDER = '0; BUF_OVER = '0;
        repeat (3) step();
        ARST = 1'b0;
        step();

        // Reset state
        chk("rst_dispon", 32'(DISPON), 32'h0);
        chk("rst_layer_en", 32'(LAYER_EN), 32'h0);
        chk("rst_layer_addr_lo", LAYER_ADDR[31:0], 32'h0);
        chk("rst_layer_addr_hi", 32'(LAYER_ADDR[57:32]), 32'h0);
        chk("rst_irq", 32'(DSP_IRQ), 32'h0);
        chk("rst_rdata", RDATA, 32'h0);
        for (int i = 0; i < 10; i++) begin
            rdchk($sformatf("rst_rd_%03h", offs[i]), offs[i], 32'h0);
        end

        // VSYNC idle high: no edge, no interrupt
        irq_seen = 1'b0;
        repeat (100) begin
            step();
            irq_seen = irq_seen | DSP_IRQ;
        end
        chk("idle_irq", 32'(irq_seen), 32'h0);
        rdchk("idle_vblank", 16'h004, 32'h0);

        // Staging without UPDREQ does not reach the active outputs
        wr(16'h100, 32'h1234_5678, 4'hF);
        wr(16'h104, 32'h1, 4'hF);
        vsync_pulse();
        chk("noupd_addr", 32'(LAYER_ADDR[28:0]), 32'h0);
        chk("noupd_en", 32'(LAYER_EN), 32'h0);
        rdchk("noupd_vblank", 16'h004, 32'h1);

        // UPDREQ then edge commits
        wr(16'h000, 32'h2, 4'hF);
        rdchk("upd_pending", 16'h000, 32'h2);
        vsync_pulse();
        chk("commit_addr0", 32'(LAYER_ADDR[28:0]), 32'h1234_5678);
        chk("commit_en", 32'(LAYER_EN), 32'h1);
        rdchk("commit_pending_clr", 16'h000, 32'h0);
        rdchk("commit_intstat", 16'h00C, 32'h5);

        // DISPON follows the write on the next cycle
        wr(16'h000, 32'h1, 4'h1);
        chk("dispon_on", 32'(DISPON), 32'h1);

        // W1C clears
        wr(16'h00C, 32'h7, 4'hF);
        wr(16'h004, 32'h1, 4'hF);
        rdchk("w1c_intstat", 16'h00C, 32'h0);
        rdchk("w1c_status", 16'h004, 32'h0);

        // Interrupt timing: fall at t0, INTSTAT at t2, IRQ at t3
        wr(16'h008, 32'h1, 4'hF);
        DSP_VSYNC_X = 1'b0;
        step();
        chk("irq_t0", 32'(DSP_IRQ), 32'h0);
        step();
        step();
        chk("irq_t2", 32'(DSP_IRQ), 32'h0);
        step();
        chk("irq_t3", 32'(DSP_IRQ), 32'h1);
        DSP_VSYNC_X = 1'b1;
        wr(16'h00C, 32'h1, 4'h1);
        chk("irq_clr_same", 32'(DSP_IRQ), 32'h1);
        step();
        chk("irq_clr_next", 32'(DSP_IRQ), 32'h0);

        // Byte lanes, address truncation, out-of-range and block miss
        wr(16'h108, 32'hFFFF_FFFF, 4'hF);
        rdchk("addr_trunc", 16'h108, 32'h1FFF_FFFF);
        rdchk("rd_miss_hold", 16'h1000, 32'h1FFF_FFFF);
        wr(16'h100, 32'h0000_00AA, 4'b0001);
        rdchk("byte_lane", 16'h100, 32'h1234_56AA);
        wr(16'h110, 32'hFFFF_FFFF, 4'hF);
        rdchk("oor_layer", 16'h110, 32'h0);
        rdchk("unmapped", 16'h020, 32'h0);
        wr(16'h1100, 32'h0, 4'hF);
        rdchk("wr_blk_miss", 16'h100, 32'h1234_56AA);

        // FIFO flag set/clear collision: set wins
        wr(16'h008, 32'h2, 4'hF);
        WRADDR = 16'h010; WDATA = 32'h0002_0000; BYTEEN = 4'hF; WREN = 1'b1;
        BUF_OVER = 2'b10;
        step();
        WREN = 1'b0; BYTEEN = 4'h0; BUF_OVER = 2'b00;
        rdchk("fifo_collide", 16'h010, 32'h0002_0000);
        chk("fifo_irq", 32'(DSP_IRQ), 32'h1);
        rdchk("fifo_intstat", 16'h00C, 32'h2);
        BUF_UNDER = 2'b01;
        step();
        BUF_UNDER = 2'b00;
        rdchk("fifo_under", 16'h010, 32'h0002_0001);
        wr(16'h010, 32'h0002_0001, 4'hF);
        rdchk("fifo_clr", 16'h010, 32'h0);
        chk("fifo_irq_clr", 32'(DSP_IRQ), 32'h0);
        wr(16'h008, 32'h0, 4'hF);

        // UPDREQ in the edge cycle: no commit until the following edge
        wr(16'h100, 32'h0ABC_DEF0, 4'hF);
        vsync_wr(16'h000, 32'h2, 4'h1);
        chk("late_upd_nocommit", 32'(LAYER_ADDR[28:0]), 32'h1234_5678);
        rdchk("late_upd_pending", 16'h000, 32'h2);
        vsync_pulse();
        chk("late_upd_commit0", 32'(LAYER_ADDR[28:0]), 32'h0ABC_DEF0);
        chk("late_upd_commit1", 32'(LAYER_ADDR[57:29]), 32'h1FFF_FFFF);
        chk("late_upd_en", 32'(LAYER_EN), 32'h1);

        // Staging write in the commit cycle: commit takes the old value
        wr(16'h100, 32'h0222_2222, 4'hF);
        wr(16'h000, 32'h2, 4'h1);
        vsync_wr(16'h100, 32'h0111_1111, 4'hF);
        chk("stg_race_active", 32'(LAYER_ADDR[28:0]), 32'h0222_2222);
        rdchk("stg_race_staging", 16'h100, 32'h0111_1111);
        rdchk("stg_race_pending", 16'h000, 32'h0);
        wr(16'h000, 32'h2, 4'h1);
        vsync_pulse();
        chk("stg_race_next", 32'(LAYER_ADDR[28:0]), 32'h0111_1111);
        rdchk("stg_race_intstat", 16'h00C, 32'h5);

        // Frame counter
        wr(16'h014, 32'h0, 4'h1);
`ifdef DISP_FRAME_CNT_EN
        exp_fc = 32'd5;
`else
        exp_fc = 32'd0;
`endif
        repeat (5) vsync_pulse();
        rdchk("framecnt", 16'h014, exp_fc);
        wr(16'h014, 32'h0, 4'b1000);
        rdchk("framecnt_clr", 16'h014, 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
